// File: rtl/fpu_chk_pkg.sv
// fpu_chk_pkg: shared op/format types, constants and fp32 helpers for the FPU scoreboard
package fpu_chk_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3} fpu_op_e;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  function automatic logic is_nan(input fp32_t f);
    return f.exp == 8'hFF && f.mant != '0;
  endfunction
  function automatic logic is_zero(input fp32_t f);
    return f.exp == '0 && f.mant == '0;
  endfunction
  function automatic logic [30:0] ulp_diff(input fp32_t a, input fp32_t b);
    return a[30:0] > b[30:0] ? a[30:0] - b[30:0] : b[30:0] - a[30:0];
  endfunction
  // Exact widening of fp32 to a double; every fp32 value is representable.
  function automatic real f32_to_real(input fp32_t f);
    int k;
    if (f.exp == 8'hFF)
      return $bitstoreal(f.mant != '0 ? 64'h7FF8_0000_0000_0000 : {f.sign, 63'h7FF0_0000_0000_0000});
    k = (f.exp == '0 ? 1 : int'(f.exp)) - 150;
    return (f.sign ? -1.0 : 1.0) * real'({f.exp != '0, f.mant}) * $bitstoreal({1'b0, 11'(k + 1023), 52'd0});
  endfunction
  // Round-to-nearest-even narrowing of a double to fp32, including subnormals and overflow to Inf.
  // Double rounding through a double is exact for +,-,*,/ of fp32 operands.
  function automatic logic [31:0] f64_to_f32(input logic [63:0] d);
    logic [63:0] sig, kept, comb;
    logic [5:0]  sh;
    logic        guard, sticky;
    int          e, shi;
    if (d[62:52] == 11'h7FF) return d[51:0] != '0 ? QNAN : {d[63], POS_INF[30:0]};
    sig = {11'd0, d[62:52] != '0, d[51:0]};
    e = (d[62:52] == '0 ? 1 : int'(d[62:52])) - 1023;
    shi = e >= -126 ? 29 : (-97 - e > 60 ? 60 : -97 - e);
    sh = shi[5:0];
    kept = sig >> sh;
    guard = sig[sh - 6'd1];
    sticky = (sig & ((64'd1 << (sh - 6'd1)) - 64'd1)) != '0;
    kept = kept + 64'(guard && (sticky || kept[0]));
    comb = (e >= -126 ? 64'(e + 126) << 23 : 64'd0) + kept;
    return comb >= 64'h7F80_0000 ? {d[63], POS_INF[30:0]} : {d[63], comb[30:0]};
  endfunction
endpackage

// File: rtl/fpu_scoreboard_ref_model.sv
// fpu_ref_model: behavioural single-precision reference for add/sub/mul/div
module fpu_ref_model
  import fpu_chk_pkg::*;
(
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] expected_o,
  output logic        supported_o
);
  real a_r, b_r, res_r;
  // Compute in double precision and round once back to fp32; NaNs come out canonical.
  always_comb begin
    a_r = f32_to_real(op_a_i);
    b_r = f32_to_real(op_b_i);
    res_r = op_i == OP_ADD ? a_r + b_r : op_i == OP_SUB ? a_r - b_r : op_i == OP_MUL ? a_r * b_r : a_r / b_r;
    supported_o = !op_i[2];
    expected_o = supported_o ? f64_to_f32($realtobits(res_r)) : '0;
  end
endmodule

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: in-order expected-result FIFO with ULP-tolerant compare and saturating statistics
module fpu_scoreboard
  import fpu_chk_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ULP_TOL = 0,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_opA,
  input  logic [31:0]            in_opB,
  input  logic [2:0]             in_op,
  input  logic                   out_valid,
  input  logic [31:0]            in_fpuout,
  output logic                   chk_valid,
  output logic                   correct,
  output logic [31:0]            fpuout,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       skip_cnt,
  output logic                   spurious_err,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [32:0]      mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      exp_val, head_exp, fpuout_q;
  logic             exp_sup, head_sup, push, pop, pass;
  logic             chk_valid_q, correct_q, spurious_q;
  logic [CNT_W-1:0] match_q, mismatch_q, skip_q;
  fpu_ref_model u_ref (
    .op_a_i      (in_opA),
    .op_b_i      (in_opB),
    .op_i        (in_op),
    .expected_o  (exp_val),
    .supported_o (exp_sup)
  );
  // Handshake, head-of-queue read and pass/fail decision for the DUT result on the bus.
  always_comb begin
    in_ready = level_q != LW'(DEPTH) || out_valid;
    push = in_valid && in_ready;
    pop = out_valid && level_q != '0;
    {head_exp, head_sup} = mem_q[rptr_q];
    pass = (is_nan(in_fpuout) && is_nan(head_exp)) || (is_zero(in_fpuout) && is_zero(head_exp)) ||
           (!is_nan(in_fpuout) && !is_nan(head_exp) && in_fpuout[31] == head_exp[31] &&
            ulp_diff(in_fpuout, head_exp) <= 31'(ULP_TOL));
    level_d = level_q + LW'(push) - LW'(pop);
  end
  // Entry storage; never read past level, so no reset is needed.
  always_ff @(posedge clk) if (push) mem_q[wptr_q] <= {exp_val, exp_sup};
  // Pointers, occupancy, registered comparison and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      chk_valid_q <= 1'b0;
      correct_q   <= 1'b0;
      fpuout_q    <= '0;
      spurious_q  <= 1'b0;
      match_q     <= '0;
      mismatch_q  <= '0;
      skip_q      <= '0;
    end else begin
      wptr_q      <= wptr_q + AW'(push);
      rptr_q      <= rptr_q + AW'(pop);
      level_q     <= level_d;
      chk_valid_q <= pop;
      spurious_q  <= spurious_q || (out_valid && level_q == '0);
      if (pop) begin
        fpuout_q   <= head_exp;
        correct_q  <= head_sup && pass;
        skip_q     <= skip_q + CNT_W'(!head_sup && skip_q != '1);
        match_q    <= match_q + CNT_W'(head_sup && pass && match_q != '1);
        mismatch_q <= mismatch_q + CNT_W'(head_sup && !pass && mismatch_q != '1);
      end
    end
  end
  assign chk_valid    = chk_valid_q;
  assign correct      = correct_q;
  assign fpuout       = fpuout_q;
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign skip_cnt     = skip_q;
  assign spurious_err = spurious_q;
  assign level        = level_q;
  // Issuing while the FIFO is full drops the transaction; flag it loudly.
  assert property (@(posedge clk) disable iff (!rst_n) !(in_valid && !in_ready));
endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard: directed stimulus with a queue-based expected-result checker
module tb_fpu_scoreboard;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_valid = 1'b0;
  logic [31:0] in_opA = '0, in_opB = '0, in_fpuout = '0;
  logic [2:0]  in_op = '0;
  logic        in_ready, chk_valid, correct, spurious_err;
  logic [31:0] fpuout;
  logic [15:0] match_cnt, mismatch_cnt, skip_cnt;
  logic [3:0]  level;
  int          checks = 0, errors = 0;
  logic [31:0] pend [$];
  logic [32:0] sb [$];
  logic [32:0] sb_e;
  logic [31:0] tab [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

  always #5 clk = ~clk;

  fpu_scoreboard #(.DEPTH(8), .ULP_TOL(1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opA       (in_opA),
    .in_opB       (in_opB),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .in_fpuout    (in_fpuout),
    .chk_valid    (chk_valid),
    .correct      (correct),
    .fpuout       (fpuout),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .skip_cnt     (skip_cnt),
    .spurious_err (spurious_err),
    .level        (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; a result pops the oldest issued expectation into the scoreboard.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] e, input bit ov, input logic [31:0] fo, input bit cor);
    @(posedge clk); #1;
    in_valid = iv; in_opA = a; in_opB = b; in_op = op; out_valid = ov; in_fpuout = fo;
    if (ov && pend.size() > 0) sb.push_back({pend.pop_front(), cor});
    if (iv) pend.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look();
    idle();
    @(negedge clk);
  endtask

  // Monitor: every compare pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && chk_valid) begin
      if (sb.size() == 0) chk("unexpected chk_valid", 32'(chk_valid), 32'd0);
      else begin
        sb_e = sb.pop_front();
        chk("fpuout", fpuout, sb_e[32:1]);
        chk("correct", 32'(correct), 32'(sb_e[0]));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset level", 32'(level), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset chk_valid", 32'(chk_valid), 0);
    chk("reset correct", 32'(correct), 0);
    chk("reset fpuout", fpuout, 0);
    chk("reset match_cnt", 32'(match_cnt), 0);
    chk("reset mismatch_cnt", 32'(mismatch_cnt), 0);
    chk("reset skip_cnt", 32'(skip_cnt), 0);
    chk("reset spurious_err", 32'(spurious_err), 0);
    rst_n = 1'b1;
    // 1.0 + 2.0 = 3.0
    step(1, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h40400000, 1);
    look();
    chk("add match_cnt", 32'(match_cnt), 1);
    // 3.0 * 2.0 = 6.0, DUT off by 1 then 2 ulp
    step(1, 32'h40400000, 32'h40000000, 2, 32'h40C00000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h40C00001, 1);
    step(1, 32'h40400000, 32'h40000000, 2, 32'h40C00000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h40C00002, 0);
    look();
    chk("ulp match_cnt", 32'(match_cnt), 2);
    chk("ulp mismatch_cnt", 32'(mismatch_cnt), 1);
    // fill to DEPTH, then push and pop together while full
    for (int i = 0; i < 8; i++) step(1, tab[i], 32'h3F800000, 0, tab[i+1], 0, 0, 0);
    look();
    chk("full level", 32'(level), 8);
    chk("full in_ready", 32'(in_ready), 0);
    step(1, tab[8], 32'h3F800000, 0, tab[9], 1, tab[1], 1);
    look();
    chk("full push+pop level", 32'(level), 8);
    for (int i = 2; i < 10; i++) step(0, 0, 0, 0, 0, 1, tab[i], 1);
    look();
    chk("drain level", 32'(level), 0);
    chk("drain match_cnt", 32'(match_cnt), 11);
    // special values
    step(1, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h7FC00001, 1);
    step(1, 32'h00000000, 32'h00000000, 0, 32'h00000000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h80000000, 1);
    step(1, 32'h3F800000, 32'h00000000, 3, 32'h7F800000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h7F800000, 1);
    step(1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h7FC00000, 0);
    step(1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hC0000000, 0);
    step(1, 32'h3F800000, 32'h00000000, 3, 32'h7F800000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h7F7FFFFF, 1);
    look();
    chk("special match_cnt", 32'(match_cnt), 15);
    chk("special mismatch_cnt", 32'(mismatch_cnt), 3);
    chk("pre spurious_err", 32'(spurious_err), 0);
    // result with nothing queued
    step(0, 0, 0, 0, 0, 1, 32'h3F800000, 0);
    look();
    chk("spurious_err", 32'(spurious_err), 1);
    chk("spurious chk_valid", 32'(chk_valid), 0);
    // unsupported op
    step(1, 32'h3F800000, 32'h40000000, 5, 32'h00000000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h40400000, 0);
    look();
    chk("skip_cnt", 32'(skip_cnt), 1);
    chk("skip match_cnt", 32'(match_cnt), 15);
    chk("skip mismatch_cnt", 32'(mismatch_cnt), 3);
    // push and result together while empty: push still queued
    step(1, 32'h40000000, 32'h40000000, 2, 32'h40800000, 1, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h40800000, 1);
    look();
    chk("empty push+pop match_cnt", 32'(match_cnt), 16);
    chk("empty push+pop level", 32'(level), 0);
    // reset mid-stream
    for (int i = 0; i < 3; i++) step(1, tab[i], 32'h3F800000, 0, tab[i+1], 0, 0, 0);
    look();
    chk("pre-reset level", 32'(level), 3);
    #2 rst_n = 1'b0;
    pend.delete();
    #1;
    chk("mid reset level", 32'(level), 0);
    chk("mid reset in_ready", 32'(in_ready), 1);
    chk("mid reset match_cnt", 32'(match_cnt), 0);
    chk("mid reset mismatch_cnt", 32'(mismatch_cnt), 0);
    chk("mid reset skip_cnt", 32'(skip_cnt), 0);
    chk("mid reset spurious_err", 32'(spurious_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 32'h40000000, 0);
    look();
    chk("post-reset spurious_err", 32'(spurious_err), 1);
    chk("post-reset chk_valid", 32'(chk_valid), 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
